// File: rtl/inst_mem_loader.sv
// inst_mem_loader: packs a byte stream into big-endian 32-bit words and writes them to instruction memory from address 0
//   Clk, Rst(active-low async)   clock / reset
//   Start, Finish                one-cycle control pulses (begin load / end load)
//   Byte_In, Byte_Valid          byte stream in, first byte lands in bits [31:24]
//   Byte_Ready                   byte accepted this cycle when Byte_Valid is high
//   Mem_We, Mem_Addr, Mem_Data   one-cycle word write strobe, address and data
//   Word_Cnt                     words written since the last Start
//   Busy, Done, Err              status: loading, complete, partial word discarded
module inst_mem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Finish,
    input  logic [7:0]        Byte_In,
    input  logic              Byte_Valid,
    output logic              Byte_Ready,
    output logic              Mem_We,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [31:0]       Mem_Data,
    output logic [ADDR_W:0]   Word_Cnt,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
    state_t            r_state;
    logic [23:0]       r_sh;
    logic [1:0]        r_bcnt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_cnt;
    logic [31:0]       r_data;
    logic              r_err;
    logic              r_fin;
    logic              w_last;
    assign w_last     = &r_addr;
    assign Byte_Ready = r_state == LOAD;
    assign Mem_We     = r_state == WRITE;
    assign Busy       = r_state == LOAD || r_state == WRITE;
    assign Done       = r_state == DONE;
    assign Mem_Addr   = r_addr;
    assign Mem_Data   = r_data;
    assign Word_Cnt   = r_cnt;
    assign Err        = r_err;
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= IDLE;
            r_sh    <= '0;
            r_bcnt  <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_fin   <= 1'b0;
        end else if (Start) begin
            // Start wins over Finish and bytes in every state; a write already on the bus still completes
            r_state <= LOAD;
            r_sh    <= '0;
            r_bcnt  <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_fin   <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (Byte_Valid) begin
                        r_sh   <= {r_sh[15:0], Byte_In};
                        r_bcnt <= r_bcnt + 2'd1;
                    end
                    if (Byte_Valid && r_bcnt == 2'd3) begin
                        // a Finish arriving with the 4th byte is held so the word is still written
                        r_data  <= {r_sh, Byte_In};
                        r_fin   <= Finish;
                        r_state <= WRITE;
                    end else if (Finish) begin
                        r_err   <= r_bcnt != 2'd0 || Byte_Valid;
                        r_state <= DONE;
                    end
                end
                WRITE: begin
                    // the address saturates at the last word so a full memory never wraps
                    r_addr  <= w_last ? r_addr : r_addr + ADDR_W'(1);
                    r_cnt   <= r_cnt + (ADDR_W + 1)'(1);
                    r_fin   <= 1'b0;
                    r_state <= (w_last || r_fin || Finish) ? DONE : LOAD;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed scoreboard bench driving a 64-word and a 4-word loader with the same stimulus
module tb_inst_mem_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       finish = 1'b0;
    logic [7:0] byte_in = '0;
    logic       byte_valid = 1'b0;
    logic       rdy6, we6, busy6, done6, err6;
    logic [5:0] addr6;
    logic [31:0] data6;
    logic [6:0] cnt6;
    logic       rdy2, we2, busy2, done2, err2;
    logic [1:0] addr2;
    logic [31:0] data2;
    logic [2:0] cnt2;
    logic [37:0] q6[$];
    logic [37:0] q2[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    inst_mem_loader #(.ADDR_W(6)) dut6 (
        .Clk(clk), .Rst(rst_n), .Start(start), .Finish(finish), .Byte_In(byte_in),
        .Byte_Valid(byte_valid), .Byte_Ready(rdy6), .Mem_We(we6), .Mem_Addr(addr6),
        .Mem_Data(data6), .Word_Cnt(cnt6), .Busy(busy6), .Done(done6), .Err(err6)
    );
    inst_mem_loader #(.ADDR_W(2)) dut2 (
        .Clk(clk), .Rst(rst_n), .Start(start), .Finish(finish), .Byte_In(byte_in),
        .Byte_Valid(byte_valid), .Byte_Ready(rdy2), .Mem_We(we2), .Mem_Addr(addr2),
        .Mem_Data(data2), .Word_Cnt(cnt2), .Busy(busy2), .Done(done2), .Err(err2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // both loaders see identical traffic and write identical words; only the small one fills up
    always @(negedge clk) begin
        if (we6) begin
            if (q6.size() == 0) chk("unexpected_write6", {26'd0, addr6, data6}, 64'hDEAD);
            else begin
                logic [37:0] e;
                e = q6.pop_front();
                chk("write_addr6", addr6, e[37:32]);
                chk("write_data6", data6, e[31:0]);
            end
        end
        if (we2) begin
            if (q2.size() == 0) chk("unexpected_write2", {30'd0, addr2, data2}, 64'hDEAD);
            else begin
                logic [37:0] e;
                e = q2.pop_front();
                chk("write_addr2", {4'd0, addr2}, e[37:32]);
                chk("write_data2", data2, e[31:0]);
            end
        end
    end

    task automatic expect_word(input logic [5:0] a, input logic [31:0] d);
        q6.push_back({a, d});
        q2.push_back({a, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        byte_in = b;
        byte_valid = 1'b1;
        while (!rdy6 && n < 20) begin
            tick();
            n++;
        end
        chk("byte_ready_wait", rdy6, 1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q6.size() != 0 || q2.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_q6", q6.size(), 0);
        chk("drain_q2", q2.size(), 0);
    endtask

    initial begin
        logic [7:0] bs[8];
        logic [9:0] rv;
        int i;
        // reset values
        tick();
        tick();
        chk("reset_outs6", {rdy6, we6, addr6, data6, cnt6, busy6, done6, err6}, 0);
        chk("reset_outs2", {rdy2, we2, addr2, data2, cnt2, busy2, done2, err2}, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_not_ready", rdy6, 0);

        // single word then clean Finish
        pulse_start();
        chk("start_busy", busy6, 1);
        expect_word(6'd0, 32'h3C081001);
        send(8'h3C); send(8'h08); send(8'h10); send(8'h01);
        chk("write_cycle_we", we6, 1);
        tick();
        pulse_finish();
        drain();
        chk("t1_done", done6, 1);
        chk("t1_cnt", cnt6, 1);
        chk("t1_err", err6, 0);
        chk("t1_busy", busy6, 0);

        // eight bytes with Byte_Valid held high
        pulse_start();
        chk("restart_cnt", cnt6, 0);
        chk("restart_done", done6, 0);
        bs = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        expect_word(6'd0, 32'hDEADBEEF);
        expect_word(6'd1, 32'h01234567);
        i = 0;
        byte_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            byte_in = bs[i & 7];
            rv[c] = rdy6;
            if (rdy6) i++;
            tick();
        end
        byte_valid = 1'b0;
        chk("t2_ready_pattern", rv, 10'b0111101111);
        drain();
        chk("t2_cnt", cnt6, 2);
        pulse_finish();
        chk("t2_done", done6, 1);

        // partial word discarded on Finish
        pulse_start();
        send(8'h20); send(8'h02);
        pulse_finish();
        drain();
        chk("t3_done", done6, 1);
        chk("t3_err", err6, 1);
        chk("t3_cnt", cnt6, 0);

        // small memory fills and refuses further bytes
        pulse_start();
        chk("t4_err_cleared", err6, 0);
        for (int w = 0; w < 4; w++) expect_word(6'(w), {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)});
        for (int k = 0; k < 16; k++) send(8'(k));
        tick();
        drain();
        chk("t4_done2", done2, 1);
        chk("t4_cnt2", cnt2, 4);
        chk("t4_err2", err2, 0);
        byte_in = 8'h99;
        byte_valid = 1'b1;
        chk("t4_refuse17", rdy2, 0);
        tick();
        byte_valid = 1'b0;
        chk("t4_still_done2", done2, 1);
        chk("t4_cnt6_continues", cnt6, 4);

        // restart mid-load
        pulse_start();
        expect_word(6'd0, 32'hA0A1A2A3);
        expect_word(6'd1, 32'hB0B1B2B3);
        send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
        send(8'hB0); send(8'hB1); send(8'hB2); send(8'hB3);
        send(8'hC0);
        pulse_start();
        chk("t5_restart_addr", addr6, 0);
        expect_word(6'd0, 32'h11223344);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        tick();
        drain();
        chk("t5_cnt", cnt6, 1);
        chk("t5_addr", addr6, 1);

        // asynchronous reset mid-word
        pulse_start();
        send(8'hAA); send(8'hBB);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_outs6", {rdy6, we6, addr6, data6, cnt6, busy6, done6, err6}, 0);
        chk("t6_async_outs2", {rdy2, we2, addr2, data2, cnt2, busy2, done2, err2}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start();
        expect_word(6'd0, 32'h55667788);
        send(8'h55); send(8'h66); send(8'h77); send(8'h88);
        tick();
        drain();
        chk("t6_cnt", cnt6, 1);
        chk("t6_err", err6, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
